// File: rtl/owl_link_pkg.sv
// Shared definitions for the owl coordinate link: frame-length constants,
// default frame header, transmitter state encodings and a byte-select helper.
package owl_link_pkg;

  localparam int         COORD_BYTES         = 18;
  localparam int         FRAME_BYTES_BASE    = 19;
  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  // Bit-level transmitter phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Frame-level sequencer phases
  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_SEND = 1'b1
  } seq_state_t;

  // Byte k (1..18) of the 144-bit {x,y,z} shadow, most significant byte first
  function automatic logic [7:0] coord_byte(input logic [143:0] shadow, input logic [4:0] idx);
    logic [7:0]   amt;
    logic [143:0] shifted;
    amt     = {idx - 5'd1, 3'b000};
    shifted = shadow << amt;
    return shifted[143:136];
  endfunction

endpackage

// File: rtl/coord_uart_tx_if.sv
// Coordinate-to-UART link interface: request/coordinates from the RAM control
// stage (master) and serial line plus status back from the transmitter (slave).
interface coord_uart_tx_if;

  logic        send_req;
  logic [47:0] x_coord;
  logic [47:0] y_coord;
  logic [47:0] z_coord;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic        req_dropped;

  modport master (
    output send_req, x_coord, y_coord, z_coord,
    input  uart_tx, busy, frame_done, req_dropped
  );

  modport slave (
    input  send_req, x_coord, y_coord, z_coord,
    output uart_tx, busy, frame_done, req_dropped
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with baud counter. A load accepted while idle, or in the
// last cycle of a stop bit, starts the next start bit with no idle gap.
// byte_done_o flags the final cycle of the stop bit so the sequencer can chain.
module uart_tx_byte
  import owl_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end_s;

  assign bit_end_s   = (cnt_q == CNT_MAX);
  assign byte_done_o = (state_q == STOP) && bit_end_s;
  assign tx_o        = tx_q;

  // State, counter and line registers with synchronous reset to idle-high
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: counter reloads on every bit boundary; line value registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load_i) begin
          state_d = START;
          cnt_d   = 16'd0;
          shift_d = byte_i;
          tx_d    = 1'b0;
        end else begin
          cnt_d = 16'd0;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = 16'd0;
          if (load_i) begin
            state_d = START;
            shift_d = byte_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/coord_uart_tx.sv
// Coordinate frame transmitter: latches x/y/z on an accepted request and sends
// header, 18 coordinate bytes (MSB first) and, when COORD_TX_CHECKSUM_EN is
// defined, an XOR checksum byte built up as each coordinate byte is loaded.
module coord_uart_tx
  import owl_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
  input logic             clk_i,
  input logic             reset_i,
  coord_uart_tx_if.slave  bus
);

`ifdef COORD_TX_CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES_BASE);
`else
  localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES_BASE - 1);
`endif

  seq_state_t     seq_q, seq_d;
  logic [4:0]     idx_q, idx_d;
  logic [143:0]   shadow_q, shadow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           drop_q, drop_d;
`ifdef COORD_TX_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic       accept_s, advance_s, finish_s, load_s, byte_done_s, tx_s;
  logic [4:0] next_idx_s;
  logic [7:0] next_byte_s, load_byte_s;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (load_s),
    .byte_i      (load_byte_s),
    .tx_o        (tx_s),
    .byte_done_o (byte_done_s)
  );

  // The frame_done cycle still counts as busy for request acceptance
  assign accept_s    = (seq_q == SEQ_IDLE) && !done_q && bus.send_req;
  assign advance_s   = (seq_q == SEQ_SEND) && byte_done_s && (idx_q != LAST_IDX);
  assign finish_s    = (seq_q == SEQ_SEND) && byte_done_s && (idx_q == LAST_IDX);
  assign next_idx_s  = idx_q + 5'd1;
`ifdef COORD_TX_CHECKSUM_EN
  assign next_byte_s = (next_idx_s == LAST_IDX) ? csum_q : coord_byte(shadow_q, next_idx_s);
`else
  assign next_byte_s = coord_byte(shadow_q, next_idx_s);
`endif
  assign load_s      = accept_s || advance_s;
  assign load_byte_s = accept_s ? HEADER_BYTE : next_byte_s;

  assign bus.uart_tx     = tx_s;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.req_dropped = drop_q;

  // Sequencer, shadow and status registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seq_q    <= SEQ_IDLE;
      idx_q    <= 5'd0;
      shadow_q <= 144'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
`ifdef COORD_TX_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
`ifdef COORD_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Frame sequencing: accept, chain next byte, or close the frame
  always_comb begin
    seq_d    = seq_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    drop_d   = drop_q;
`ifdef COORD_TX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (accept_s) begin
      seq_d    = SEQ_SEND;
      idx_d    = 5'd0;
      shadow_d = {bus.x_coord, bus.y_coord, bus.z_coord};
      busy_d   = 1'b1;
      drop_d   = 1'b0;
`ifdef COORD_TX_CHECKSUM_EN
      csum_d   = 8'd0;
`endif
    end else if (advance_s) begin
      idx_d = next_idx_s;
`ifdef COORD_TX_CHECKSUM_EN
      if (next_idx_s <= 5'(COORD_BYTES)) begin
        csum_d = csum_q ^ next_byte_s;
      end else begin
        csum_d = csum_q;
      end
`endif
    end else if (finish_s) begin
      seq_d  = SEQ_IDLE;
      busy_d = 1'b0;
      done_d = 1'b1;
    end else begin
      seq_d = seq_q;
    end
    if (!accept_s && bus.send_req && (busy_q || done_q)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_d;
    end
  end

endmodule

// File: tb/tb_coord_uart_tx.sv
// Scoreboard bench for coord_uart_tx: the driver pushes the expected frame
// bytes when a request is issued; a bit-centre UART receiver pops and compares.
module tb_coord_uart_tx;
  import owl_link_pkg::*;

  localparam int CPB = 4;
`ifdef COORD_TX_CHECKSUM_EN
  localparam int NBYTES = 20;
`else
  localparam int NBYTES = 19;
`endif
  localparam int FRAME_CYC = CPB * 10 * NBYTES;

  logic clk = 1'b0;
  logic reset;
  coord_uart_tx_if bus();

  coord_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;
  int rst_gen = 0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame: header, 18 coordinate bytes MSB first, optional XOR checksum
  task automatic push_frame(input logic [47:0] x, input logic [47:0] y, input logic [47:0] z);
    logic [143:0] cat;
    logic [7:0]   b;
    logic [7:0]   cs;
    cat = {x, y, z};
    cs  = 8'h00;
    sb.push_back(8'hA5);
    for (int k = 0; k < 18; k++) begin
      b  = cat[143 - 8*k -: 8];
      cs = cs ^ b;
      sb.push_back(b);
    end
`ifdef COORD_TX_CHECKSUM_EN
    sb.push_back(cs);
`endif
  endtask

  // Called at a negedge; issues a one-cycle request that must be accepted
  task automatic send(input logic [47:0] x, input logic [47:0] y, input logic [47:0] z, input string name);
    bus.send_req = 1'b1;
    bus.x_coord  = x;
    bus.y_coord  = y;
    bus.z_coord  = z;
    push_frame(x, y, z);
    @(posedge clk);
    @(negedge clk);
    bus.send_req = 1'b0;
    acc = cyc;
    check({name, "_start_bit"}, 64'(bus.uart_tx), 64'd0);
    check({name, "_busy_on"}, 64'(bus.busy), 64'd1);
  endtask

  // Waits (bounded) for frame_done, leaving the caller in the frame_done cycle
  task automatic wait_done(input string name);
    for (int i = 0; i < FRAME_CYC + 200 && bus.frame_done !== 1'b1; i++) @(negedge clk);
    check({name, "_done_cycles"}, 64'(cyc - acc), 64'(FRAME_CYC));
    check({name, "_busy_off"}, 64'(bus.busy), 64'd0);
    check({name, "_bytes_left"}, 64'(sb.size()), 64'd0);
  endtask

  // UART receiver: samples the centre of each bit and compares against the scoreboard
  initial begin : rx
    logic [7:0] d;
    logic       st, sp;
    int         gen;
    forever begin
      @(negedge clk);
      if (bus.uart_tx === 1'b0 && reset === 1'b0) begin
        gen = rst_gen;
        repeat (2) @(negedge clk);
        st = bus.uart_tx;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          d[b] = bus.uart_tx;
        end
        repeat (CPB) @(negedge clk);
        sp = bus.uart_tx;
        if (gen == rst_gen) begin
          check("rx_start_bit", 64'(st), 64'd0);
          check("rx_stop_bit", 64'(sp), 64'd1);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected_byte: got %0h expected no byte", d);
          end else begin
            check("rx_byte", 64'(d), 64'(sb.pop_front()));
          end
        end
      end
    end
  end

  initial begin : drv
    int pulses, lows;
    reset        = 1'b1;
    bus.send_req = 1'b0;
    bus.x_coord  = 48'd0;
    bus.y_coord  = 48'd0;
    bus.z_coord  = 48'd0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 64'(bus.uart_tx), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_req_dropped", 64'(bus.req_dropped), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single set bit: A5, 00x5, 01, 00x12, checksum 01
    send(48'h0000_0000_0001, 48'd0, 48'd0, "t1");
    wait_done("t1");
    @(negedge clk);
    check("t1_done_one_cycle", 64'(bus.frame_done), 64'd0);

    // Mixed pattern
    send(48'h1234_5678_9ABC, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_8000, "t2");
    wait_done("t2");
    @(negedge clk);

    // Request while busy with changed coordinates: dropped, frame unchanged
    send(48'hA1A2_A3A4_A5A6, 48'h0102_0304_0506, 48'hF0E0_D0C0_B0A0, "t3");
    repeat (99) @(negedge clk);
    bus.send_req = 1'b1;
    bus.x_coord  = 48'h5555_5555_5555;
    bus.y_coord  = 48'hAAAA_AAAA_AAAA;
    bus.z_coord  = 48'h3C3C_3C3C_3C3C;
    @(negedge clk);
    bus.send_req = 1'b0;
    check("t3_dropped_set", 64'(bus.req_dropped), 64'd1);
    wait_done("t3");
    repeat (60) @(negedge clk);
    check("t3_no_second_frame", 64'(bus.busy), 64'd0);
    check("t3_dropped_sticky", 64'(bus.req_dropped), 64'd1);
    send(48'h0000_0000_00FF, 48'h8000_0000_0000, 48'h0F0F_0F0F_0F0F, "t3b");
    check("t3_dropped_cleared", 64'(bus.req_dropped), 64'd0);
    wait_done("t3b");
    @(negedge clk);

    // Reset mid-frame
    send(48'hDEAD_BEEF_CAFE, 48'h0123_4567_89AB, 48'hCDEF_0011_2233, "t4");
    repeat (99) @(negedge clk);
    bus.send_req = 1'b1;
    @(negedge clk);
    bus.send_req = 1'b0;
    repeat (149) @(negedge clk);
    reset = 1'b1;
    rst_gen++;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("t4_rst_uart_tx", 64'(bus.uart_tx), 64'd1);
    check("t4_rst_busy", 64'(bus.busy), 64'd0);
    check("t4_rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("t4_rst_dropped", 64'(bus.req_dropped), 64'd0);
    pulses = 0;
    lows   = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) pulses++;
      if (bus.uart_tx !== 1'b1) lows++;
    end
    check("t4_no_frame_done", 64'(pulses), 64'd0);
    check("t4_line_idle", 64'(lows), 64'd0);
    send(48'h0000_0000_0000, 48'h7777_7777_7777, 48'h0000_0000_0042, "t4b");
    wait_done("t4b");
    @(negedge clk);

    // Back-to-back: request on the frame_done cycle dropped, next cycle accepted
    send(48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999, "t5");
    wait_done("t5");
    bus.send_req = 1'b1;
    bus.x_coord  = 48'hFEDC_BA98_7654;
    bus.y_coord  = 48'h3210_0123_4567;
    bus.z_coord  = 48'h89AB_CDEF_0000;
    @(negedge clk);
    check("t5_done_one_cycle", 64'(bus.frame_done), 64'd0);
    check("t5_dropped_on_done", 64'(bus.req_dropped), 64'd1);
    check("t5_not_started", 64'(bus.busy), 64'd0);
    send(48'hFEDC_BA98_7654, 48'h3210_0123_4567, 48'h89AB_CDEF_0000, "t5b");
    check("t5_dropped_cleared", 64'(bus.req_dropped), 64'd0);
    wait_done("t5b");
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
